// File: rtl/if_prefetch_queue.sv
// if_prefetch_queue
//   Instruction prefetch unit in front of the ID stage. It issues word-addressed
//   reads to instruction memory and buffers the returned words, each with its
//   NPC, in a DEPTH-entry FIFO. It handles branch redirect (flush and squash of
//   in-flight reads) and freezes on HLT.
//
// Ports
//   clk1           single clock, all state updates on posedge
//   rst            synchronous, active-high reset
//   redirect_valid taken branch; restart fetch at redirect_pc
//   redirect_pc    branch target (word address)
//   halt           HLT retired; freeze fetch until reset
//   imem_req       read request valid
//   imem_addr      read word address (fetch_pc[AW-1:0])
//   imem_ack       request accepted (req && ack = transfer)
//   imem_rvalid    read data valid, responses in request order
//   imem_rdata     instruction word
//   id_valid       FIFO head valid
//   id_ready       ID accepts head (valid && ready = pop)
//   id_ir          instruction at head
//   id_npc         address of head instruction + 1
//
// States
//   RUN    | fetching and delivering
//   HALTED | HLT seen; no requests, no delivery, late responses discarded
module if_prefetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned AW       = 10,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic          clk1,
  input  logic          rst,
  input  logic          redirect_valid,
  input  logic [31:0]   redirect_pc,
  input  logic          halt,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic          imem_rvalid,
  input  logic [31:0]   imem_rdata,
  output logic          id_valid,
  input  logic          id_ready,
  output logic [31:0]   id_ir,
  output logic [31:0]   id_npc
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam logic [CW:0] CREDIT = DEPTH[CW:0];

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  state_t state, state_next;

  logic [31:0]   fetch_pc, resp_pc;
  logic [CW-1:0] count, outstanding, outstanding_next, drop;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [31:0]   ir_q  [DEPTH];
  logic [31:0]   npc_q [DEPTH];
  logic [CW:0]   in_use;
  logic          running, transfer, pop, push, flush, redirect_take;

  always_ff @(posedge clk1) begin
    if (rst) state <= RUN;
    else     state <= state_next;
  end

  // Credit covers both buffered and in-flight words, so the FIFO can never
  // be asked to accept more than DEPTH entries.
  assign in_use = {1'b0, count} + {1'b0, outstanding};

  always_comb begin
    state_next = state;
    imem_req   = 1'b0;
    id_valid   = 1'b0;
    case (state)
      RUN: begin
        imem_req = (in_use < CREDIT);
        id_valid = (count != '0);
        if (halt) state_next = HALTED;
      end
      HALTED: begin
        state_next = HALTED;
      end
    endcase
  end

  assign running       = (state == RUN);
  assign transfer      = imem_req & imem_ack;
  assign pop           = id_valid & id_ready;
  assign flush         = running & redirect_valid;
  assign redirect_take = flush & ~halt;
  // A response is kept only when nothing older is still being squashed and
  // no redirect lands in the same cycle.
  assign push          = imem_rvalid & running & ~redirect_valid & (drop == '0);

  assign outstanding_next = outstanding + CW'(transfer) - CW'(imem_rvalid);

  always_ff @(posedge clk1) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      count       <= '0;
      outstanding <= '0;
      drop        <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        ir_q[i]  <= '0;
        npc_q[i] <= '0;
      end
    end else begin
      outstanding <= outstanding_next;

      if (redirect_take)  fetch_pc <= redirect_pc;
      else if (transfer)  fetch_pc <= fetch_pc + 32'd1;

      if (redirect_take)  resp_pc <= redirect_pc;
      else if (push)      resp_pc <= resp_pc + 32'd1;

      // Every read still owed by the bus after this edge belongs to the old
      // path; the in-order bus lets a plain counter squash them exactly.
      if (flush)                           drop <= outstanding_next;
      else if (imem_rvalid && drop != '0)  drop <= drop - 1'b1;

      if (flush) begin
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        count <= count + CW'(push) - CW'(pop);
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end

      if (push) begin
        ir_q[wr_ptr]  <= imem_rdata;
        npc_q[wr_ptr] <= resp_pc + 32'd1;
      end
    end
  end

  assign imem_addr = fetch_pc[AW-1:0];
  assign id_ir     = ir_q[rd_ptr];
  assign id_npc    = npc_q[rd_ptr];

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Testbench for if_prefetch_queue: instruction memory with configurable
// latency, a queue-level reference model, a vector table for the stall/credit
// sequence, directed redirect/halt/reset sequences and a randomized run.
module tb_if_prefetch_queue;
  localparam int          DEPTH    = 4;
  localparam int          AW       = 10;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic          clk1 = 1'b0;
  logic          rst = 1'b1;
  logic          redirect_valid = 1'b0;
  logic [31:0]   redirect_pc = 32'h0;
  logic          halt = 1'b0;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack = 1'b0;
  logic          imem_rvalid = 1'b0;
  logic [31:0]   imem_rdata = 32'h0;
  logic          id_valid;
  logic          id_ready = 1'b0;
  logic [31:0]   id_ir;
  logic [31:0]   id_npc;

  always #5 clk1 = ~clk1;

  if_prefetch_queue #(.DEPTH(DEPTH), .AW(AW), .RESET_PC(RESET_PC)) dut (
    .clk1(clk1), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halt(halt), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .id_valid(id_valid),
    .id_ready(id_ready), .id_ir(id_ir), .id_npc(id_npc)
  );

  int          errors = 0;
  int          checks = 0;
  int unsigned cyc = 0;
  int unsigned lat_min = 1, lat_max = 1;
  bit          scramble = 1'b0;

  typedef struct { logic [31:0] ir; logic [31:0] npc; } ent_t;
  typedef struct { logic [31:0] pc; bit stale; } fl_t;
  typedef struct { logic [AW-1:0] addr; int unsigned due; } rd_t;

  ent_t        m_fifo[$];
  fl_t         m_infl[$];
  rd_t         pend[$];
  logic [31:0] m_pc;
  bit          m_halted;

  typedef struct { bit rdy; bit req; logic [AW-1:0] addr; bit vld; logic [31:0] npc; } vec_t;
  vec_t tbl[12];

  function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
    logic [31:0] w;
    w = 32'(a);
    if (scramble) return (w * 32'h9E3779B1) ^ 32'h5A5A0000;
    return 32'h1000 + w;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_fifo.delete();
    m_infl.delete();
    pend.delete();
    m_pc     = RESET_PC;
    m_halted = 1'b0;
  endtask

  task automatic drive_resp();
    if (!rst && pend.size() != 0 && pend[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(pend[0].addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
    end
  endtask

  // One clock cycle: compare against the model away from the edge, then
  // advance memory and model with the inputs the DUT saw at the edge.
  task automatic step();
    bit            e_req, e_valid, s_ack, s_rv, s_rdy, s_redir, s_halt, s_rst, s_req, xfer;
    logic [AW-1:0] s_addr;
    logic [31:0]   s_rpc;
    int unsigned   due;
    fl_t           f;
    drive_resp();
    @(negedge clk1);
    e_req   = !m_halted && (m_fifo.size() + m_infl.size() < DEPTH);
    e_valid = !m_halted && (m_fifo.size() != 0);
    if (!rst) begin
      chk("imem_req", 32'(imem_req), 32'(e_req));
      if (e_req) chk("imem_addr", 32'(imem_addr), 32'(m_pc[AW-1:0]));
      chk("id_valid", 32'(id_valid), 32'(e_valid));
      if (e_valid) begin
        chk("id_ir", id_ir, m_fifo[0].ir);
        chk("id_npc", id_npc, m_fifo[0].npc);
      end
      if (imem_rvalid) chk("rvalid_outstanding", 32'(m_infl.size() != 0), 32'd1);
    end
    s_ack = imem_ack;  s_rv = imem_rvalid;  s_rdy = id_ready;
    s_redir = redirect_valid;  s_rpc = redirect_pc;  s_halt = halt;  s_rst = rst;
    s_req = imem_req;  s_addr = imem_addr;
    @(posedge clk1);
    if (s_rst) begin
      model_reset();
    end else begin
      if (s_rv) void'(pend.pop_front());
      if (s_req && s_ack) begin
        due = cyc + $urandom_range(lat_max, lat_min);
        if (pend.size() != 0 && due <= pend[pend.size()-1].due) due = pend[pend.size()-1].due + 1;
        pend.push_back('{addr: s_addr, due: due});
      end
      xfer = e_req && s_ack;
      if (!m_halted) begin
        if (e_valid && s_rdy) void'(m_fifo.pop_front());
        if (s_rv && m_infl.size() != 0) begin
          f = m_infl.pop_front();
          if (!f.stale && !s_redir)
            m_fifo.push_back('{ir: mem_word(f.pc[AW-1:0]), npc: f.pc + 32'd1});
        end
        if (xfer) begin
          m_infl.push_back('{pc: m_pc, stale: 1'b0});
          m_pc = m_pc + 32'd1;
        end
        if (s_redir) begin
          m_fifo.delete();
          for (int i = 0; i < m_infl.size(); i++) m_infl[i].stale = 1'b1;
          if (!s_halt) m_pc = s_rpc;
        end
        if (s_halt) m_halted = 1'b1;
      end else if (s_rv && m_infl.size() != 0) begin
        void'(m_infl.pop_front());
      end
    end
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;  redirect_valid = 1'b0;  halt = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic wait_valid(input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (id_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s: id_valid stayed low for 40 cycles (cycle %0d)", name, cyc);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int n;
    model_reset();

    tbl[0]  = '{1'b0, 1'b1, 10'd0, 1'b0, 32'd0};
    tbl[1]  = '{1'b0, 1'b1, 10'd1, 1'b0, 32'd0};
    tbl[2]  = '{1'b0, 1'b1, 10'd2, 1'b1, 32'd1};
    tbl[3]  = '{1'b0, 1'b1, 10'd3, 1'b1, 32'd1};
    tbl[4]  = '{1'b0, 1'b0, 10'd0, 1'b1, 32'd1};
    tbl[5]  = '{1'b0, 1'b0, 10'd0, 1'b1, 32'd1};
    tbl[6]  = '{1'b1, 1'b0, 10'd0, 1'b1, 32'd1};
    tbl[7]  = '{1'b1, 1'b1, 10'd4, 1'b1, 32'd2};
    tbl[8]  = '{1'b1, 1'b1, 10'd5, 1'b1, 32'd3};
    tbl[9]  = '{1'b1, 1'b1, 10'd6, 1'b1, 32'd4};
    tbl[10] = '{1'b1, 1'b1, 10'd7, 1'b1, 32'd5};
    tbl[11] = '{1'b1, 1'b1, 10'd8, 1'b1, 32'd6};

    // Streaming at latency 1, ID always ready
    lat_min = 1;  lat_max = 1;  imem_ack = 1'b1;  id_ready = 1'b1;
    do_reset();
    chk("reset_id_valid", 32'(id_valid), 32'd0);
    chk("reset_id_ir", id_ir, 32'd0);
    chk("reset_id_npc", id_npc, 32'd0);
    chk("reset_imem_req", 32'(imem_req), 32'd1);
    for (int k = 0; k < 12; k++) begin
      if (k < 2) begin
        chk("t1_valid_early", 32'(id_valid), 32'd0);
      end else begin
        chk("t1_valid", 32'(id_valid), 32'd1);
        chk("t1_npc", id_npc, 32'(k - 1));
        chk("t1_ir", id_ir, 32'h1000 + 32'(k - 2));
      end
      step();
    end

    // Stalled ID fills the queue to the credit limit, then drains
    id_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      id_ready = tbl[i].rdy;
      chk("t2_req", 32'(imem_req), 32'(tbl[i].req));
      if (tbl[i].req) chk("t2_addr", 32'(imem_addr), 32'(tbl[i].addr));
      chk("t2_valid", 32'(id_valid), 32'(tbl[i].vld));
      if (tbl[i].vld) begin
        chk("t2_npc", id_npc, tbl[i].npc);
        chk("t2_ir", id_ir, 32'h1000 + tbl[i].npc - 32'd1);
      end
      step();
    end
    repeat (10) step();

    // Redirect with three reads in flight at latency 3
    lat_min = 3;  lat_max = 3;  id_ready = 1'b1;  imem_ack = 1'b1;
    do_reset();
    n = 0;
    while (n < 40 && !(m_infl.size() == 3 && !m_halted)) begin
      step();
      n++;
    end
    chk("t3_reach_three_inflight", 32'(m_infl.size()), 32'd3);
    redirect_valid = 1'b1;  redirect_pc = 32'h40;  imem_ack = 1'b0;
    step();
    redirect_valid = 1'b0;  imem_ack = 1'b1;
    chk("t3_flush_valid", 32'(id_valid), 32'd0);
    wait_valid("t3_wait", ok);
    if (ok) begin
      chk("t3_ir", id_ir, 32'h1040);
      chk("t3_npc", id_npc, 32'h41);
    end
    repeat (6) step();

    // Redirect coinciding with an accepted request and a response
    lat_min = 1;  lat_max = 1;
    do_reset();
    repeat (9) step();
    chk("t4_addr_pre", 32'(imem_addr), 32'd9);
    chk("t4_req_pre", 32'(imem_req), 32'd1);
    redirect_valid = 1'b1;  redirect_pc = 32'h20;
    step();
    redirect_valid = 1'b0;
    chk("t4_flush_valid", 32'(id_valid), 32'd0);
    chk("t4_req_after", 32'(imem_req), 32'd1);
    chk("t4_addr_after", 32'(imem_addr), 32'h20);
    wait_valid("t4_wait", ok);
    if (ok) begin
      chk("t4_npc", id_npc, 32'h21);
      chk("t4_ir", id_ir, 32'h1020);
    end
    repeat (6) step();

    // Halt with two queued and one outstanding; redirect ignored; reset restarts
    lat_min = 3;  lat_max = 3;  id_ready = 1'b0;  imem_ack = 1'b1;
    do_reset();
    repeat (3) step();
    imem_ack = 1'b0;
    step();
    halt = 1'b1;
    step();
    halt = 1'b0;  imem_ack = 1'b1;  id_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("t5_halt_valid", 32'(id_valid), 32'd0);
      chk("t5_halt_req", 32'(imem_req), 32'd0);
      redirect_valid = (i == 3);
      redirect_pc    = 32'h80;
      step();
    end
    redirect_valid = 1'b0;
    do_reset();
    chk("t5_restart_req", 32'(imem_req), 32'd1);
    chk("t5_restart_addr", 32'(imem_addr), 32'(RESET_PC[AW-1:0]));
    wait_valid("t5_wait", ok);
    if (ok) chk("t5_npc", id_npc, RESET_PC + 32'd1);

    // Reset mid-operation with the credit fully used
    lat_min = 2;  lat_max = 2;  id_ready = 1'b0;  imem_ack = 1'b1;
    do_reset();
    repeat (4) step();
    chk("t6_full_req", 32'(imem_req), 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_valid", 32'(id_valid), 32'd0);
    chk("t6_req", 32'(imem_req), 32'd1);
    chk("t6_addr", 32'(imem_addr), 32'(RESET_PC[AW-1:0]));
    id_ready = 1'b1;
    repeat (10) step();

    // Randomized traffic against the model
    scramble = 1'b1;  lat_min = 1;  lat_max = 4;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      imem_ack       = ($urandom % 4) != 0;
      id_ready       = ($urandom % 10) < 7;
      redirect_valid = ($urandom % 20) == 0;
      redirect_pc    = (($urandom % 4) == 0) ? 32'hFFFF_FFFE : $urandom;
      halt           = ($urandom % 400) == 0;
      rst            = (m_halted && ($urandom % 16) == 0) || (($urandom % 500) == 0);
      step();
    end
    rst = 1'b0;  halt = 1'b0;  redirect_valid = 1'b0;
    repeat (5) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
